// File: rtl/move_engine_if.sv
// Move, judge and result handshakes of the Connect-4 move engine.
// slave: the engine; master: game controller plus win judge.
interface move_engine_if;
    logic        clr;
    logic        mv_ready;
    logic        mv_valid;
    logic [2:0]  mv_col;
    logic        mv_player;
    logic [41:0] occupied;
    logic [41:0] whos;
    logic        jd_op_ready;
    logic        jd_op_valid;
    logic        jd_re_ready;
    logic        jd_re_valid;
    logic        jd_re_fin;
    logic        res_ready;
    logic        res_valid;
    logic [1:0]  res_code;
    logic [2:0]  res_row;

    modport slave (
        input  clr, mv_valid, mv_col, mv_player,
        input  jd_op_ready, jd_re_valid, jd_re_fin, res_ready,
        output mv_ready, occupied, whos, jd_op_valid,
        output jd_re_ready, res_valid, res_code, res_row
    );

    modport master (
        output clr, mv_valid, mv_col, mv_player,
        output jd_op_ready, jd_re_valid, jd_re_fin, res_ready,
        input  mv_ready, occupied, whos, jd_op_valid,
        input  jd_re_ready, res_valid, res_code, res_row
    );
endinterface

// File: rtl/move_engine.sv
// Connect-4 board owner and move sequencer feeding the win judge.
// Define TURN_CHECK_EN to reject moves made out of turn.
module move_engine (
    input  logic         clk,
    input  logic         rst_n,
    move_engine_if.slave bus
);
    localparam int unsigned ROWS = 6;
    localparam int unsigned COLS = 7;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_JD_REQ, S_JD_WAIT, S_RESULT
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  col_q, col_d;
    logic        player_q, player_d;
    logic [2:0]  r_q, r_d;
    logic [41:0] occupied_q, occupied_d;
    logic [41:0] whos_q, whos_d;
    logic        game_over_q, game_over_d;
    logic        turn_q, turn_d;
    logic        mv_ready_q, mv_ready_d;
    logic        jd_op_valid_q, jd_op_valid_d;
    logic        jd_re_ready_q, jd_re_ready_d;
    logic        res_valid_q, res_valid_d;
    logic [1:0]  res_code_q, res_code_d;
    logic [2:0]  res_row_q, res_row_d;

    logic [5:0]  idx;
    logic        turn_bad;
    logic        illegal_req;

`ifdef TURN_CHECK_EN
    assign turn_bad = bus.mv_player != turn_q;
`else
    assign turn_bad = 1'b0;
`endif

    assign illegal_req = (bus.mv_col > 3'd6) || game_over_q || turn_bad;
    assign idx = 6'(r_q) * 6'(COLS) + 6'(col_q);

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        player_d      = player_q;
        r_d           = r_q;
        occupied_d    = occupied_q;
        whos_d        = whos_q;
        game_over_d   = game_over_q;
        turn_d        = turn_q;
        mv_ready_d    = mv_ready_q;
        jd_op_valid_d = jd_op_valid_q;
        jd_re_ready_d = jd_re_ready_q;
        res_valid_d   = res_valid_q;
        res_code_d    = res_code_q;
        res_row_d     = res_row_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.clr) begin
                    occupied_d  = '0;
                    whos_d      = '0;
                    game_over_d = 1'b0;
                    turn_d      = 1'b0;
                end else if (bus.mv_valid && mv_ready_q) begin
                    col_d      = bus.mv_col;
                    player_d   = bus.mv_player;
                    mv_ready_d = 1'b0;
                    r_d        = 3'(ROWS - 1);
                    if (illegal_req) begin
                        state_d     = S_RESULT;
                        res_valid_d = 1'b1;
                        res_code_d  = 2'b01;
                        res_row_d   = 3'd7;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (!occupied_q[idx]) begin
                    occupied_d[idx] = 1'b1;
                    whos_d[idx]     = player_q;
                    res_row_d       = r_q;
                    jd_op_valid_d   = 1'b1;
                    state_d         = S_JD_REQ;
                end else if (r_q == 3'd0) begin
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                    res_code_d  = 2'b01;
                    res_row_d   = 3'd7;
                end else begin
                    r_d = r_q - 3'd1;
                end
            end
            S_JD_REQ: begin
                if (bus.jd_op_ready) begin
                    jd_op_valid_d = 1'b0;
                    jd_re_ready_d = 1'b1;
                    state_d       = S_JD_WAIT;
                end
            end
            S_JD_WAIT: begin
                // Board is frozen here: the judge reads it combinationally.
                if (bus.jd_re_valid) begin
                    jd_re_ready_d = 1'b0;
                    res_valid_d   = 1'b1;
                    turn_d        = ~turn_q;
                    state_d       = S_RESULT;
                    if (bus.jd_re_fin) begin
                        res_code_d  = 2'b10;
                        game_over_d = 1'b1;
                    end else if (&occupied_q) begin
                        res_code_d  = 2'b11;
                        game_over_d = 1'b1;
                    end else begin
                        res_code_d = 2'b00;
                    end
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    mv_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            player_q      <= 1'b0;
            r_q           <= '0;
            occupied_q    <= '0;
            whos_q        <= '0;
            game_over_q   <= 1'b0;
            turn_q        <= 1'b0;
            mv_ready_q    <= 1'b1;
            jd_op_valid_q <= 1'b0;
            jd_re_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_code_q    <= '0;
            res_row_q     <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            player_q      <= player_d;
            r_q           <= r_d;
            occupied_q    <= occupied_d;
            whos_q        <= whos_d;
            game_over_q   <= game_over_d;
            turn_q        <= turn_d;
            mv_ready_q    <= mv_ready_d;
            jd_op_valid_q <= jd_op_valid_d;
            jd_re_ready_q <= jd_re_ready_d;
            res_valid_q   <= res_valid_d;
            res_code_q    <= res_code_d;
            res_row_q     <= res_row_d;
        end
    end

    assign bus.mv_ready    = mv_ready_q;
    assign bus.occupied    = occupied_q;
    assign bus.whos        = whos_q;
    assign bus.jd_op_valid = jd_op_valid_q;
    assign bus.jd_re_ready = jd_re_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_code    = res_code_q;
    assign bus.res_row     = res_row_q;
endmodule
